// File: rtl/read_fsm.sv
//==============================================================================
// read_fsm : RV32I register-read / immediate-decode stage, rev 1.0
//==============================================================================
`default_nettype none

module read_fsm #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IR,
  input  logic [XLEN-1:0] WB_data,
  input  logic [4:0]      WB_address,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] IR_out,
  output logic [XLEN-1:0] A_out,
  output logic [XLEN-1:0] B_out,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] I_out
);

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_imm;

  assign w_rs1    = IR[19:15];
  assign w_rs2    = IR[24:20];
  assign w_opcode = IR[6:0];

  // A write-back landing this cycle is forwarded so the operand is never stale.
  assign w_a = (w_rs1 == 5'd0)      ? '0      :
               (WB_address == w_rs1) ? WB_data : r_regs[w_rs1];
  assign w_b = (w_rs2 == 5'd0)      ? '0      :
               (WB_address == w_rs2) ? WB_data : r_regs[w_rs2];

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:
        w_imm = {{20{IR[31]}}, IR[31:20]};
      c_OP_STORE:
        w_imm = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      c_OP_BRANCH:
        w_imm = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        w_imm = {IR[31:12], 12'b0};
      c_OP_JAL:
        w_imm = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WB_address != 5'd0) begin
      r_regs[WB_address] <= WB_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IR_out <= '0;
      A_out  <= '0;
      B_out  <= '0;
      PC_out <= '0;
      I_out  <= '0;
    end else begin
      IR_out <= IR;
      A_out  <= w_a;
      B_out  <= w_b;
      PC_out <= PC;
      I_out  <= w_imm;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_fsm.sv
//==============================================================================
// tb_read_fsm : table-driven and randomized checks for read_fsm, rev 1.0
//==============================================================================
`default_nettype none

module tb_read_fsm;

  logic        clk;
  logic        rst;
  logic [31:0] IR;
  logic [31:0] WB_data;
  logic [4:0]  WB_address;
  logic [31:0] PC;
  logic [31:0] IR_out;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic [31:0] PC_out;
  logic [31:0] I_out;

  int errors = 0;
  int checks = 0;

  read_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .IR         (IR),
    .WB_data    (WB_data),
    .WB_address (WB_address),
    .PC         (PC),
    .IR_out     (IR_out),
    .A_out      (A_out),
    .B_out      (B_out),
    .PC_out     (PC_out),
    .I_out      (I_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ei;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] m_regs [32];

  function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] pc,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ei);
    vec_t v;
    v.ir = ir; v.pc = pc; v.wa = wa; v.wd = wd;
    v.ea = ea; v.eb = eb; v.ei = ei;
    return v;
  endfunction

  // Immediate rebuilt from field arithmetic on the signed instruction word.
  function automatic logic [31:0] m_imm(input logic [31:0] ir);
    int s;
    int op;
    s  = $signed(ir);
    op = int'(ir & 32'h7F);
    if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73)
      return 32'(s >>> 20);
    if (op == 'h23)
      return 32'(((s >>> 25) * 32) + int'((ir >> 7) & 32'h1F));
    if (op == 'h63)
      return 32'(((s >>> 31) * 4096) + int'(((ir >> 7) & 1) * 2048)
                 + int'(((ir >> 25) & 32'h3F) * 32) + int'(((ir >> 8) & 32'hF) * 2));
    if (op == 'h37 || op == 'h17)
      return ir & 32'hFFFFF000;
    if (op == 'h6F)
      return 32'(((s >>> 31) * 1048576) + int'(((ir >> 12) & 32'hFF) * 4096)
                 + int'(((ir >> 20) & 1) * 2048) + int'(((ir >> 21) & 32'h3FF) * 2));
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (idx == wa) return wd;
    return m_regs[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    IR = v.ir; PC = v.pc; WB_address = v.wa; WB_data = v.wd;
    step();
    chk("IR_out", IR_out, v.ir);
    chk("PC_out", PC_out, v.pc);
    chk("A_out",  A_out,  v.ea);
    chk("B_out",  B_out,  v.eb);
    chk("I_out",  I_out,  v.ei);
    if (v.wa != 0) m_regs[v.wa] = v.wd;
  endtask

  initial begin
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ei;
    logic [6:0]  ops [10];

    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    rst = 1'b1; IR = 32'h0; PC = 32'h0; WB_address = 5'd0; WB_data = 32'h0;
    #2;
    chk("rst IR_out", IR_out, 32'h0);
    chk("rst A_out",  A_out,  32'h0);
    chk("rst B_out",  B_out,  32'h0);
    chk("rst PC_out", PC_out, 32'h0);
    chk("rst I_out",  I_out,  32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      WB_address = 5'(r); WB_data = 32'(r);
      step();
      if (r != 0) m_regs[r] = 32'(r);
    end

    for (int a = 0; a <= 30; a += 2) begin
      r1 = 5'(a); r2 = 5'(a + 1);
      ir = {7'b0, r2, r1, 3'b000, 5'b0, 7'b0110011};
      vt.push_back(mk(ir, 32'(a * 4), 5'd0, 32'h0, 32'(a), 32'(a + 1), 32'h0));
    end
    vt.push_back(mk(32'h00000033, 32'h0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0));
    vt.push_back(mk(32'h00000033, 32'h0, 5'd0, 32'h0,        32'h0, 32'h0, 32'h0));
    vt.push_back(mk(32'hFFF00093, 32'h100, 5'd0, 32'h0, 32'h0, 32'd31, 32'hFFFFFFFF));
    vt.push_back(mk(32'h0020A423, 32'h104, 5'd0, 32'h0, 32'd1, 32'd2,  32'h00000008));
    vt.push_back(mk(32'h123451B7, 32'h108, 5'd0, 32'h0, 32'd8, 32'd3,  32'h12345000));
    vt.push_back(mk(32'hFE208EE3, 32'h10C, 5'd0, 32'h0, 32'd1, 32'd2,  32'hFFFFFFFC));
    vt.push_back(mk(32'h0010006F, 32'h110, 5'd0, 32'h0, 32'd0, 32'd1,  32'h00000800));
    vt.push_back(mk(32'hFFFFFFFF, 32'h114, 5'd0, 32'h0, 32'd31, 32'd31, 32'h0));
    foreach (vt[i]) apply(vt[i]);

    // Bypass on rs1, then on rs2, then confirm the writes stuck.
    apply(mk(32'h00628033, 32'h200, 5'd5, 32'd99,  32'd99, 32'd6,   32'h0));
    apply(mk(32'h00628033, 32'h204, 5'd6, 32'd123, 32'd99, 32'd123, 32'h0));
    apply(mk(32'h00628033, 32'h208, 5'd0, 32'h0,   32'd99, 32'd123, 32'h0));

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("async IR_out", IR_out, 32'h0);
    chk("async A_out",  A_out,  32'h0);
    chk("async B_out",  B_out,  32'h0);
    chk("async PC_out", PC_out, 32'h0);
    chk("async I_out",  I_out,  32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    apply(mk(32'h00038033, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0));

    for (int n = 0; n < 400; n++) begin
      ir = $urandom;
      if ($urandom_range(3) != 0) ir[6:0] = ops[$urandom_range(9)];
      pc = $urandom;
      wd = $urandom;
      wa = 5'($urandom_range(31));
      ea = m_read(ir[19:15], wa, wd);
      eb = m_read(ir[24:20], wa, wd);
      ei = m_imm(ir);
      apply(mk(ir, pc, wa, wd, ea, eb, ei));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
